// File: rtl/i2c_txn_sequencer_if.sv
`default_nettype none
// =============================================================================
// i2c_txn_sequencer_if : host command, byte streams and byte-master control
// Rev 1.0
// =============================================================================
interface i2c_txn_sequencer_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [6:0]    cmd_addr;
  logic          cmd_rw;
  logic [LW-1:0] cmd_len;

  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    wr_data;

  logic          rd_valid;
  logic [7:0]    rd_data;

  logic          busy;
  logic          done;
  logic          err;

  logic          m_start;
  logic          m_stop;
  logic          m_i2c_en;
  logic [7:0]    m_tx_data;
  logic          m_ready;
  logic          m_tx_done;
  logic [7:0]    m_rx_data;

  // sequencer view
  modport slave (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_len,
    input  wr_valid, wr_data,
    input  m_ready, m_tx_done, m_rx_data,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, err,
    output m_start, m_stop, m_i2c_en, m_tx_data
  );

  // host plus byte-master view
  modport master (
    output cmd_valid, cmd_addr, cmd_rw, cmd_len,
    output wr_valid, wr_data,
    output m_ready, m_tx_done, m_rx_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, err,
    input  m_start, m_stop, m_i2c_en, m_tx_data
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// =============================================================================
// i2c_txn_sequencer : sequences START / address / data bytes / STOP on a byte master
// Rev 1.0
// =============================================================================
module i2c_txn_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 4096,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  i2c_txn_sequencer_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [LW-1:0] MAX_LEN_V  = LW'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);

  // {i2c_en, start, stop}
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_START = 3'b110;
  localparam logic [2:0] OP_WRITE = 3'b100;
  localparam logic [2:0] OP_READ  = 3'b111;
  localparam logic [2:0] OP_STOP  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADDR   = 4'd2,
    S_WFETCH = 4'd3,
    S_WDATA  = 4'd4,
    S_RDATA  = 4'd5,
    S_STOP   = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  state_t        state, state_nxt;
  logic [6:0]    addr_q;
  logic          rw_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt;
  logic          phase;
  logic [SW-1:0] settle;
  logic [TW-1:0] tmo;
  logic          err_q;
  logic [7:0]    tx_q;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;

  logic          in_op;
  logic          op_complete;
  logic          op_timeout;
  logic          len_bad;
  logic          last_byte;
  logic          restart;
  logic          accept;
  logic          wr_take;
  logic          cmd_ready;
  logic          wr_ready;
  logic          done;
  logic [2:0]    op_lv;
  logic          unused_tx_done;

  assign unused_tx_done = bus.m_tx_done;

  assign in_op = (state == S_START) || (state == S_ADDR) || (state == S_WDATA) ||
                 (state == S_RDATA) || (state == S_STOP);
  // Completion wins over a timeout landing in the same cycle.
  assign op_complete = in_op && phase && bus.m_ready && (settle == SETTLE_END);
  assign op_timeout  = in_op && !op_complete && (tmo == TMO_LAST);
  assign len_bad     = (bus.cmd_len == '0) || (bus.cmd_len > MAX_LEN_V);
  assign last_byte   = (cnt == (len_q - LW'(1)));

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    accept    = 1'b0;
    wr_take   = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    op_lv     = OP_NONE;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          restart = 1'b1;
          state_nxt = len_bad ? S_ERR : S_START;
        end
      end
      S_START: begin
        op_lv = OP_START;
        if (op_complete) begin
          state_nxt = S_ADDR;
          restart   = 1'b1;
        end else if (op_timeout) begin
          state_nxt = S_STOP;
          restart   = 1'b1;
        end
      end
      S_ADDR: begin
        op_lv = OP_WRITE;
        if (op_complete) begin
          state_nxt = rw_q ? S_RDATA : S_WFETCH;
          restart   = 1'b1;
        end else if (op_timeout) begin
          state_nxt = S_STOP;
          restart   = 1'b1;
        end
      end
      S_WFETCH: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          wr_take   = 1'b1;
          state_nxt = S_WDATA;
          restart   = 1'b1;
        end
      end
      S_WDATA: begin
        op_lv = OP_WRITE;
        if (op_complete) begin
          state_nxt = last_byte ? S_STOP : S_WFETCH;
          restart   = 1'b1;
        end else if (op_timeout) begin
          state_nxt = S_STOP;
          restart   = 1'b1;
        end
      end
      S_RDATA: begin
        op_lv = OP_READ;
        // Staying in RDATA with a fresh restart re-issues the READ op.
        if (op_complete) begin
          state_nxt = last_byte ? S_STOP : S_RDATA;
          restart   = 1'b1;
        end else if (op_timeout) begin
          state_nxt = S_STOP;
          restart   = 1'b1;
        end
      end
      S_STOP: begin
        op_lv = OP_STOP;
        if (op_complete) begin
          state_nxt = S_DONE;
        end else if (op_timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      settle     <= '0;
      tmo        <= '0;
      err_q      <= 1'b0;
      tx_q       <= 8'hFF;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= 1'b0;

      if (accept) begin
        addr_q <= bus.cmd_addr;
        rw_q   <= bus.cmd_rw;
        len_q  <= bus.cmd_len;
        cnt    <= '0;
        err_q  <= len_bad;
      end

      // Phase A waits for the master to drop m_ready, phase B for a stable m_ready run.
      if (restart) begin
        phase  <= 1'b0;
        settle <= '0;
        tmo    <= '0;
      end else if (in_op) begin
        tmo <= tmo + TW'(1);
        if (!phase) begin
          if (!bus.m_ready) phase <= 1'b1;
        end else begin
          settle <= bus.m_ready ? settle + SW'(1) : '0;
        end
      end

      if (op_timeout) err_q <= 1'b1;

      if ((state == S_START) && op_complete) tx_q <= {addr_q, rw_q};
      if (wr_take) tx_q <= bus.wr_data;

      if ((state == S_RDATA) && op_complete) begin
        rd_data_q  <= bus.m_rx_data;
        rd_valid_q <= 1'b1;
      end

      if (((state == S_WDATA) || (state == S_RDATA)) && op_complete) cnt <= cnt + LW'(1);
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign bus.m_i2c_en  = op_lv[2];
  assign bus.m_start   = op_lv[1];
  assign bus.m_stop    = op_lv[0];
  assign bus.m_tx_data = tx_q;
endmodule
`default_nettype wire
